// File: rtl/sm_sched_pkg.sv
// Shared definitions for the stepper drive scheduler: default timing parameters,
// FSM state codes, owner codes and a small edge helper.
package sm_sched_pkg;

  localparam int unsigned PW_DEF        = 17;
  localparam int unsigned CW_DEF        = 16;
  localparam int unsigned P_IDLE_DEF    = 8333;
  localparam int unsigned P_MIN_DEF     = 1000;
  localparam int unsigned RAMP_STEP_DEF = 64;
  localparam int unsigned UPD_DIV_DEF   = 5000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_TRACK    = 3'd1;
  localparam logic [2:0] ST_JOG      = 3'd2;
  localparam logic [2:0] ST_RUN_N    = 3'd3;
  localparam logic [2:0] ST_STOPPING = 3'd4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_TR   = 2'd1,
    OWN_MAN  = 2'd2
  } owner_e;

  function automatic logic rising(input logic now, input logic prev);
    return now & ~prev;
  endfunction

endpackage

// File: rtl/sm_ramp.sv
// Slew limiter for the step period: a free-running divider issues ramp ticks, and on
// each tick the period moves toward the clamped target by at most RAMP_STEP.
module sm_ramp
  import sm_sched_pkg::*;
#(
  parameter int unsigned PW        = PW_DEF,
  parameter int unsigned P_IDLE    = P_IDLE_DEF,
  parameter int unsigned P_MIN     = P_MIN_DEF,
  parameter int unsigned RAMP_STEP = RAMP_STEP_DEF,
  parameter int unsigned UPD_DIV   = UPD_DIV_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          hold_idle_i,
  input  logic [PW-1:0] target_i,
  output logic [PW-1:0] period_o,
  output logic          at_idle_o
);

  localparam int unsigned   DW       = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(UPD_DIV - 1);
  localparam logic [PW-1:0] PER_HI   = PW'(P_IDLE);
  localparam logic [PW-1:0] PER_LO   = PW'(P_MIN);
  localparam logic [PW-1:0] STEP     = PW'(RAMP_STEP);

  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] tgt;
  logic [PW-1:0] gap;
  logic [PW-1:0] delta;
  logic          tick;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // The clamp keeps the period inside [P_MIN, P_IDLE] whatever the requesters ask for.
  always_comb begin
    tgt = target_i;
    if (target_i < PER_LO) begin
      tgt = PER_LO;
    end else if (target_i > PER_HI) begin
      tgt = PER_HI;
    end
  end

  always_comb begin
    gap   = (tgt >= per_q) ? (tgt - per_q) : (per_q - tgt);
    delta = (gap > STEP) ? STEP : gap;
    per_d = per_q;
    if (hold_idle_i) begin
      per_d = PER_HI;
    end else if (tick) begin
      if (tgt > per_q) begin
        per_d = per_q + delta;
      end else begin
        per_d = per_q - delta;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      per_q <= PER_HI;
    end else begin
      div_q <= div_d;
      per_q <= per_d;
    end
  end

  assign period_o  = per_q;
  assign at_idle_o = (per_q == PER_HI);

endmodule

// File: rtl/sm_drive_sched.sv
// Arbitrates the single pulse generator between tracking and manual jog/N-step requests,
// ramping the period through sm_ramp and only reversing direction at standstill.
module sm_drive_sched
  import sm_sched_pkg::*;
#(
  parameter int unsigned PW        = PW_DEF,
  parameter int unsigned CW        = CW_DEF,
  parameter int unsigned P_IDLE    = P_IDLE_DEF,
  parameter int unsigned P_MIN     = P_MIN_DEF,
  parameter int unsigned RAMP_STEP = RAMP_STEP_DEF,
  parameter int unsigned UPD_DIV   = UPD_DIV_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tr_en_i,
  input  logic [PW-1:0] tr_period_i,
  input  logic          tr_dir_i,
  input  logic          man_start_i,
  input  logic          man_start_n_i,
  input  logic          man_stop_i,
  input  logic [CW-1:0] man_count_i,
  input  logic [PW-1:0] man_period_i,
  input  logic          man_dir_i,
  input  logic          drv_step_i,
  output logic [PW-1:0] drv_period_o,
  output logic          drv_en_o,
  output logic          drv_dir_o,
  output logic [1:0]    owner_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [PW-1:0] PER_HI = PW'(P_IDLE);

  logic [2:0]    state_q, state_d;
  logic          dir_q, dir_d;
  owner_e        own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          step_q;
  logic          step_rise;
  logic          in_idle;
  logic          at_idle;
  logic [PW-1:0] target;

  assign in_idle   = (state_q == ST_IDLE);
  assign step_rise = rising(drv_step_i, step_q);

  always_comb begin
    target = PER_HI;
    case (state_q)
      ST_TRACK:        target = tr_period_i;
      ST_JOG, ST_RUN_N: target = man_period_i;
      default:         target = PER_HI;
    endcase
  end

  // Holding the ramp at P_IDLE while idle guarantees every move starts from the slow end.
  sm_ramp #(
    .PW        (PW),
    .P_IDLE    (P_IDLE),
    .P_MIN     (P_MIN),
    .RAMP_STEP (RAMP_STEP),
    .UPD_DIV   (UPD_DIV)
  ) u_ramp (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .hold_idle_i (in_idle),
    .target_i    (target),
    .period_o    (drv_period_o),
    .at_idle_o   (at_idle)
  );

  // A stop pulse in IDLE outranks any start in the same cycle, so nothing is launched.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!man_stop_i) begin
          if (man_start_n_i) begin
            if (man_count_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN_N;
              cnt_d   = man_count_i;
              dir_d   = man_dir_i;
              own_d   = OWN_MAN;
            end
          end else if (man_start_i) begin
            state_d = ST_JOG;
            dir_d   = man_dir_i;
            own_d   = OWN_MAN;
          end else if (tr_en_i) begin
            state_d = ST_TRACK;
            dir_d   = tr_dir_i;
            own_d   = OWN_TR;
          end
        end
      end
      ST_TRACK: begin
        if (man_stop_i || !tr_en_i || (tr_dir_i != dir_q)) begin
          state_d = ST_STOPPING;
        end
      end
      ST_JOG: begin
        if (man_stop_i) begin
          state_d = ST_STOPPING;
        end
      end
      ST_RUN_N: begin
        if (man_stop_i) begin
          state_d = ST_STOPPING;
          cnt_d   = '0;
        end else if (step_rise) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            own_d   = OWN_NONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_STOPPING: begin
        if (at_idle) begin
          state_d = ST_IDLE;
          own_d   = OWN_NONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        own_d   = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      own_q   <= OWN_NONE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      step_q  <= drv_step_i;
    end
  end

  // The enable tracks non-IDLE exactly: STOPPING keeps it high until the ramp is home.
  assign drv_en_o  = ~in_idle;
  assign busy_o    = ~in_idle;
  assign drv_dir_o = dir_q;
  assign owner_o   = own_q;
  assign done_o    = done_q;

endmodule
